// File: rtl/order_sequencer_if.sv
// Bundle between the order sequencer, the message parser feeding it and the
// shared UART transmitter it drives.
interface order_sequencer_if;
    logic [15:0] price;
    logic [15:0] threshold;
    logic        new_price;
    logic        tx_busy;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        position;
    logic [7:0]  order_count;
    logic [7:0]  dropped_count;
    logic        busy;

    modport slave (
        input  price, threshold, new_price, tx_busy,
        output tx_byte, tx_start, position, order_count, dropped_count, busy
    );

    modport master (
        output price, threshold, new_price, tx_busy,
        input  tx_byte, tx_start, position, order_count, dropped_count, busy
    );
endinterface

// File: rtl/order_sequencer.sv
// Flat/long trading rule plus ASCII order emitter ("B:nnnnn\n" / "S:nnnnn\n")
// feeding a start/busy UART, with a single latest-price slot and cooldown.
module order_sequencer #(
    parameter int unsigned COOLDOWN_CYCLES = 1000,
    parameter logic [15:0] HYSTERESIS      = 16'd0
) (
    input  logic clk,
    input  logic rst_n,
    order_sequencer_if.slave bus
);

    localparam int CW = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, DECIDE, CONVERT, SEND, WAIT_TX, COOLDOWN
    } state_t;

    state_t        state, state_n;
    logic [15:0]   snap_price, snap_thr;
    logic [15:0]   pend_price, pend_thr;
    logic          pend_valid;
    logic [15:0]   shift;
    logic [19:0]   bcd, bcd_adj;
    logic [3:0]    conv_cnt;
    logic [2:0]    idx;
    logic          sell;
    logic          wait_first;
    logic [CW-1:0] cd_cnt;
    logic          position;
    logic [7:0]    order_count, dropped_count;
    logic [7:0]    msg_byte;
    logic          do_buy, do_sell;
    logic          tx_start, busy, last_done, advance;
    logic [7:0]    tx_byte;

    // Sell side widened to 17 bits so threshold + HYSTERESIS cannot wrap.
    always_comb begin
        do_buy  = !position && (snap_price < snap_thr);
        do_sell = position &&
                  ({1'b0, snap_price} > ({1'b0, snap_thr} + {1'b0, HYSTERESIS}));
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        case (idx)
            3'd0:    msg_byte = sell ? 8'h53 : 8'h42;
            3'd1:    msg_byte = 8'h3A;
            3'd2:    msg_byte = {4'h3, bcd[19:16]};
            3'd3:    msg_byte = {4'h3, bcd[15:12]};
            3'd4:    msg_byte = {4'h3, bcd[11:8]};
            3'd5:    msg_byte = {4'h3, bcd[7:4]};
            3'd6:    msg_byte = {4'h3, bcd[3:0]};
            default: msg_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        tx_start  = 1'b0;
        tx_byte   = 8'h00;
        busy      = (state != IDLE);
        last_done = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE:     if (bus.new_price || pend_valid) state_n = DECIDE;
            DECIDE:   state_n = (do_buy || do_sell) ? CONVERT : IDLE;
            CONVERT:  if (conv_cnt == 4'd15) state_n = SEND;
            SEND: begin
                tx_byte = msg_byte;
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    state_n  = WAIT_TX;
                end
            end
            // The transmitter only raises busy the cycle after our start.
            WAIT_TX: begin
                if (!wait_first && !bus.tx_busy) begin
                    if (idx == 3'd7) begin
                        last_done = 1'b1;
                        state_n   = (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
                    end else begin
                        advance = 1'b1;
                        state_n = SEND;
                    end
                end
            end
            COOLDOWN: if (cd_cnt == CW'(1)) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_price  <= '0;
            snap_thr    <= '0;
            shift       <= '0;
            bcd         <= '0;
            conv_cnt    <= '0;
            idx         <= '0;
            sell        <= 1'b0;
            wait_first  <= 1'b0;
            cd_cnt      <= '0;
            position    <= 1'b0;
            order_count <= '0;
        end else begin
            wait_first <= tx_start;
            case (state)
                IDLE: begin
                    if (bus.new_price) begin
                        snap_price <= bus.price;
                        snap_thr   <= bus.threshold;
                    end else if (pend_valid) begin
                        snap_price <= pend_price;
                        snap_thr   <= pend_thr;
                    end
                end
                DECIDE: begin
                    sell     <= do_sell;
                    bcd      <= '0;
                    shift    <= snap_price;
                    conv_cnt <= '0;
                    idx      <= '0;
                end
                CONVERT: begin
                    {bcd, shift} <= {bcd_adj, shift} << 1;
                    conv_cnt     <= conv_cnt + 4'd1;
                end
                WAIT_TX: begin
                    if (advance) idx <= idx + 3'd1;
                    if (last_done) begin
                        position    <= ~position;
                        order_count <= order_count + 8'd1;
                        cd_cnt      <= CW'(COOLDOWN_CYCLES);
                    end
                end
                COOLDOWN: cd_cnt <= cd_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // Latest-price slot: newest wins, overwrites are counted (saturating).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid    <= 1'b0;
            pend_price    <= '0;
            pend_thr      <= '0;
            dropped_count <= '0;
        end else if (state != IDLE) begin
            if (bus.new_price) begin
                pend_valid <= 1'b1;
                pend_price <= bus.price;
                pend_thr   <= bus.threshold;
                if (pend_valid && dropped_count != 8'hFF)
                    dropped_count <= dropped_count + 8'd1;
            end
        end else if (!bus.new_price) begin
            pend_valid <= 1'b0;
        end
    end

    assign bus.tx_start      = tx_start;
    assign bus.tx_byte       = tx_byte;
    assign bus.busy          = busy;
    assign bus.position      = position;
    assign bus.order_count   = order_count;
    assign bus.dropped_count = dropped_count;

endmodule

// File: tb/tb_order_sequencer.sv
// Two sequencers (no hysteresis + short cooldown, hysteresis 5 + no cooldown)
// share one price feed and are checked every cycle against an event-level model.
module tb_order_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] price, threshold;
    logic        new_price;
    int          tx_len;
    int          tx_cnt0, tx_cnt1;
    int          cyc;
    int          errors, checks;

    order_sequencer_if b0();
    order_sequencer_if b1();

    assign b0.price     = price;
    assign b0.threshold = threshold;
    assign b0.new_price = new_price;
    assign b0.tx_busy   = (tx_cnt0 != 0);
    assign b1.price     = price;
    assign b1.threshold = threshold;
    assign b1.new_price = new_price;
    assign b1.tx_busy   = (tx_cnt1 != 0);

    order_sequencer #(.COOLDOWN_CYCLES(4), .HYSTERESIS(16'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));
    order_sequencer #(.COOLDOWN_CYCLES(0), .HYSTERESIS(16'd5)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART stand-in: busy for tx_len cycles starting the cycle after a start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           tx_cnt0 <= 0;
        else if (b0.tx_start) tx_cnt0 <= tx_len;
        else if (tx_cnt0 != 0) tx_cnt0 <= tx_cnt0 - 1;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           tx_cnt1 <= 0;
        else if (b1.tx_start) tx_cnt1 <= tx_len;
        else if (tx_cnt1 != 0) tx_cnt1 <= tx_cnt1 - 1;
    end

    // Reference model, one entry per DUT.
    int          hyst[2] = '{0, 5};
    int          cool[2] = '{4, 0};
    int          idle_at[2], upd_at[2], s0[2], blen[2];
    bit          tog[2], pos[2], pend_v[2], mon[2];
    logic [7:0]  oc[2], dc[2];
    logic [15:0] pend_p[2], pend_t[2];
    logic [7:0]  mbytes[2][8];
    logic [7:0]  cap0[$];
    int          capc0[$];

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s dut%0d cycle %0d observed=%0h expected=%0h",
                   tag, d, cyc, obs, exp);
        end
    endtask

    // Order message timing: first start 18 cycles after the decision strobe,
    // then one start per (busy length + 2) cycles, 8 bytes in total.
    task automatic accept(input int d, input logic [15:0] p, input logic [15:0] th,
                          input int t);
        bit buy, sel;
        int v;
        buy = !pos[d] && (p < th);
        sel = pos[d] && (int'(p) > int'(th) + hyst[d]);
        if (buy || sel) begin
            v = int'(p);
            mbytes[d][0] = sel ? 8'h53 : 8'h42;
            mbytes[d][1] = 8'h3A;
            mbytes[d][2] = 8'(8'h30 + (v / 10000) % 10);
            mbytes[d][3] = 8'(8'h30 + (v / 1000) % 10);
            mbytes[d][4] = 8'(8'h30 + (v / 100) % 10);
            mbytes[d][5] = 8'(8'h30 + (v / 10) % 10);
            mbytes[d][6] = 8'(8'h30 + v % 10);
            mbytes[d][7] = 8'h0A;
            mon[d]     = 1'b1;
            blen[d]    = tx_len;
            s0[d]      = t + 18;
            upd_at[d]  = t + 18 + 8 * (tx_len + 2);
            idle_at[d] = upd_at[d] + cool[d];
            tog[d]     = 1'b1;
        end else begin
            idle_at[d] = t + 2;
        end
    endtask

    task automatic model_step();
        int t;
        t = cyc;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                idle_at[d] = 0; upd_at[d] = -1; tog[d] = 0; pos[d] = 0;
                oc[d] = 0; dc[d] = 0; pend_v[d] = 0; mon[d] = 0;
            end else begin
                if (tog[d] && t + 1 == upd_at[d]) begin
                    pos[d] = !pos[d];
                    oc[d]  = oc[d] + 8'd1;
                    tog[d] = 0;
                end
                if (t >= idle_at[d]) begin
                    if (new_price) accept(d, price, threshold, t);
                    else if (pend_v[d]) begin
                        pend_v[d] = 0;
                        accept(d, pend_p[d], pend_t[d], t);
                    end
                end else if (new_price) begin
                    if (pend_v[d] && dc[d] != 8'hFF) dc[d] = dc[d] + 8'd1;
                    pend_v[d] = 1;
                    pend_p[d] = price;
                    pend_t[d] = threshold;
                end
            end
        end
    endtask

    task automatic check_dut(input int d, input logic st, input logic [7:0] by,
                             input logic bz, input logic ps, input logic [7:0] o,
                             input logic [7:0] dct);
        bit es;
        int k;
        es = 0;
        k  = 0;
        if (mon[d] && cyc >= s0[d] && ((cyc - s0[d]) % (blen[d] + 2)) == 0) begin
            k  = (cyc - s0[d]) / (blen[d] + 2);
            es = (k < 8);
        end
        chk("tx_start", d, 32'(st), 32'(es));
        if (es) chk("tx_byte", d, 32'(by), 32'(mbytes[d][k]));
        chk("busy", d, 32'(bz), 32'(cyc < idle_at[d]));
        chk("position", d, 32'(ps), 32'(pos[d]));
        chk("order_count", d, 32'(o), 32'(oc[d]));
        chk("dropped_count", d, 32'(dct), 32'(dc[d]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_dut(0, b0.tx_start, b0.tx_byte, b0.busy, b0.position,
                  b0.order_count, b0.dropped_count);
        check_dut(1, b1.tx_start, b1.tx_byte, b1.busy, b1.position,
                  b1.order_count, b1.dropped_count);
        if (b0.tx_start) begin
            cap0.push_back(b0.tx_byte);
            capc0.push_back(cyc);
        end
    endtask

    task automatic strobe(input logic [15:0] p, input logic [15:0] th);
        price = p;
        threshold = th;
        new_price = 1'b1;
        tick();
        new_price = 1'b0;
    endtask

    function automatic bit all_idle();
        return cyc >= idle_at[0] && cyc >= idle_at[1] && !pend_v[0] && !pend_v[1];
    endfunction

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (all_idle()) return;
            tick();
        end
        chk("idle_timeout", 0, 32'(all_idle()), 32'd1);
    endtask

    task automatic check_msg(input string tag, input logic [7:0] exp[8], input int t0);
        chk({tag, "_len"}, 0, 32'(cap0.size()), 32'd8);
        if (cap0.size() == 8) begin
            for (int i = 0; i < 8; i++) chk(tag, 0, 32'(cap0[i]), 32'(exp[i]));
            chk({tag, "_latency"}, 0, 32'(capc0[0] - t0), 32'd18);
        end
    endtask

    logic [7:0] buy_msg[8]  = '{8'h42, 8'h3A, 8'h30, 8'h30, 8'h39, 8'h39, 8'h39, 8'h0A};
    logic [7:0] sell_msg[8] = '{8'h53, 8'h3A, 8'h30, 8'h31, 8'h30, 8'h30, 8'h31, 8'h0A};
    logic [7:0] full_msg[8] = '{8'h53, 8'h3A, 8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0A};
    logic [7:0] b10_msg[8]  = '{8'h42, 8'h3A, 8'h30, 8'h30, 8'h30, 8'h31, 8'h30, 8'h0A};

    initial begin
        int t0;
        errors = 0; checks = 0; cyc = 0;
        rst_n = 1'b0; new_price = 1'b0; price = '0; threshold = '0; tx_len = 10;

        // Reset with random inputs: every output held at zero.
        for (int i = 0; i < 6; i++) begin
            price = 16'($urandom); threshold = 16'($urandom); new_price = 1'($urandom);
            tick();
            chk("rst_tx_byte", 0, 32'(b0.tx_byte), 32'd0);
            chk("rst_tx_byte", 1, 32'(b1.tx_byte), 32'd0);
        end
        new_price = 1'b0;
        rst_n = 1'b1;

        // Buy while flat.
        cap0.delete(); capc0.delete();
        t0 = cyc;
        strobe(16'd999, 16'd1000);
        wait_idle(400);
        check_msg("buy_msg", buy_msg, t0);
        chk("buy_position", 0, 32'(b0.position), 32'd1);
        chk("buy_orders", 1, 32'(b1.order_count), 32'd1);

        // Sell threshold with and without hysteresis.
        strobe(16'd1000, 16'd1000);
        wait_idle(400);
        cap0.delete(); capc0.delete();
        t0 = cyc;
        strobe(16'd1001, 16'd1000);
        wait_idle(400);
        check_msg("sell_msg", sell_msg, t0);
        chk("sell_h0_position", 0, 32'(b0.position), 32'd0);
        chk("sell_h5_hold", 1, 32'(b1.position), 32'd1);
        strobe(16'd1005, 16'd1000);
        wait_idle(400);
        chk("h5_1005_hold", 1, 32'(b1.position), 32'd1);
        strobe(16'd1006, 16'd1000);
        wait_idle(400);
        chk("h5_1006_sell", 1, 32'(b1.position), 32'd0);

        // Equality while flat: no trade, back to idle two cycles later.
        strobe(16'd500, 16'd500);
        chk("eq_busy_t1", 0, 32'(b0.busy), 32'd1);
        tick();
        chk("eq_busy_t2", 0, 32'(b0.busy), 32'd0);
        chk("eq_busy_t2", 1, 32'(b1.busy), 32'd0);

        // Burst during transmission: 20 overwritten by 30, 30 decided after.
        cap0.delete(); capc0.delete();
        t0 = cyc;
        strobe(16'd10, 16'd100);
        repeat (30) tick();
        strobe(16'd20, 16'd100);
        repeat (30) tick();
        strobe(16'd30, 16'd100);
        wait_idle(1000);
        check_msg("burst_msg", b10_msg, t0);
        chk("burst_dropped", 0, 32'(b0.dropped_count), 32'd1);
        chk("burst_dropped", 1, 32'(b1.dropped_count), 32'd1);
        chk("burst_position", 0, 32'(b0.position), 32'd1);
        chk("burst_orders", 0, 32'(b0.order_count), 32'd3);

        // Full scale with a slow transmitter.
        tx_len = 200;
        cap0.delete(); capc0.delete();
        t0 = cyc;
        strobe(16'hFFFF, 16'd0);
        wait_idle(3000);
        check_msg("full_msg", full_msg, t0);
        chk("full_orders", 1, 32'(b1.order_count), 32'd4);
        tx_len = 10;

        // Reset in the cycle a start is being requested.
        t0 = cyc;
        strobe(16'd123, 16'd200);
        while (cyc < t0 + 18) tick();
        chk("pre_rst_start", 0, 32'(b0.tx_start), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_start", 0, 32'(b0.tx_start), 32'd0);
        chk("midrst_start", 1, 32'(b1.tx_start), 32'd0);
        chk("midrst_position", 0, 32'(b0.position), 32'd0);
        chk("midrst_orders", 1, 32'(b1.order_count), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Random price feed around the threshold band.
        for (int i = 0; i < 3000; i++) begin
            if (all_idle() && ($urandom % 40) == 0) tx_len = int'($urandom_range(1, 6));
            new_price = (($urandom % 9) == 0);
            price     = 16'($urandom_range(985, 1020));
            threshold = 16'($urandom_range(995, 1005));
            tick();
        end
        new_price = 1'b0;
        wait_idle(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/order_sequencer.md
# order_sequencer

Trading decision and order-emission controller that sits between the ASCII message parser and the shared UART transmitter. On each `new_price` strobe it snapshots price and threshold and applies a flat/long position rule. When the rule calls for a trade, it converts the price to decimal and sequences an 8-byte ASCII order message (`B:nnnnn\n` or `S:nnnnn\n`) into the transmitter through a start/busy handshake. A single-entry "latest price" slot and a post-order cooldown keep it stable under bursty market input.

## Interface
- `COOLDOWN_CYCLES`, 1000: idle cycles enforced after an order's last byte completes; 0 disables cooldown.
- `HYSTERESIS`, 0: margin added to the threshold for the sell rule; unsigned, 16-bit.
- `clk`  in  1  single system clock; everything is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `price`  in  16  latest parsed price; valid in the cycle `new_price` is high.
- `threshold`  in  16  current threshold; sampled together with `price`.
- `new_price`  in  1  one-cycle strobe, a new price is available.
- `tx_busy`  in  1  UART transmitter busy; it must rise in the cycle after an accepted `tx_start`.
- `tx_byte`  out  8  byte to transmit; valid while `tx_start` is high.
- `tx_start`  out  1  one-cycle transmit request.
- `position`  out  1  0 = flat, 1 = long.
- `order_count`  out  8  orders sent; wraps at 256.
- `dropped_count`  out  8  price events overwritten in the pending slot; saturates at 255.
- `busy`  out  1  high in every state except IDLE.

## Operation
- State machine: IDLE, DECIDE, CONVERT, SEND, WAIT_TX, COOLDOWN.
- **IDLE**
  - If `new_price` is high, latch `price` and `threshold` into the snapshot, then go to DECIDE.
  - Otherwise, if the pending slot is valid, load the snapshot from the slot, clear the slot, then go to DECIDE.
- **DECIDE**
  - Buy: `position`=0 and price < threshold.
  - Sell: `position`=1 and price > threshold + `HYSTERESIS`. Compute the right side in 17 bits, so there is no wrap.
  - Buy or sell: clear the BCD register, go to CONVERT. Otherwise return to IDLE with no output activity.
  - Equality never triggers a trade.
- **CONVERT**
  - Double-dabble conversion of the 16-bit snapshot into 5 BCD digits.
  - Exactly 16 cycles, one shift per cycle. Each BCD nibble ≥ 5 has 3 added before its shift.
  - Then go to SEND with byte index 0.
- **SEND**
  - When `tx_busy`=0, assert `tx_start` for one cycle with `tx_byte` = message[index], then go to WAIT_TX.
  - Message byte sequence:
    - index 0: `B` (0x42) for a buy, `S` (0x53) for a sell.
    - index 1: `:`.
    - indices 2–6: ASCII digits, most significant first, leading zeros kept.
    - index 7: `\n` (0x0A).
- **WAIT_TX**
  - Ignore `tx_busy` in the first cycle, then wait for `tx_busy`=0.
  - If index < 7: increment index and go to SEND.
  - If index = 7: toggle `position`, increment `order_count`, then go to COOLDOWN.
  - If `COOLDOWN_CYCLES`=0, go directly to IDLE.
- **COOLDOWN**
  - Load the counter with `COOLDOWN_CYCLES` on entry, decrement each cycle, go to IDLE when it reaches 1.
  - Counter width is `$clog2(COOLDOWN_CYCLES+1)`.
- **Pending slot**
  - Any `new_price` seen outside IDLE writes `price` and `threshold` into the slot and sets it valid.
  - If the slot was already valid, the data is overwritten (newest wins) and `dropped_count` increments.
  - A `new_price` in IDLE bypasses the slot and leaves it untouched.
- **Reset**
  - While `rst_n`=0, all outputs and state are 0: state IDLE, `tx_start`=0, `tx_byte`=0, `position`=0, both counters 0, slot invalid, `busy`=0.
  - Reset mid-message abandons the message immediately; bytes already sent are not retracted.

## Timing
- With `new_price` high in cycle t: DECIDE is in t+1, CONVERT is in t+2..t+17, and the first `tx_start` is in t+18 at the earliest (`tx_busy` low).
- No-trade decision: back in IDLE at t+2.
- Consecutive `tx_start` pulses are separated by at least 3 cycles. Each byte waits for the transmitter to finish.
- `tx_start` is never high in two adjacent cycles and is never asserted while `tx_busy`=1.
- `position` and `order_count` update in the cycle after the last byte's `tx_busy` falls.
- The pending slot is consumed in the first IDLE cycle with no fresh `new_price`. A fresh strobe in IDLE takes priority; the slot stays queued.

## Test plan
- Reset: hold `rst_n`=0 with random inputs. All outputs must be 0. Assert reset in the middle of a message: `tx_start` goes low immediately and `position`=0.
- Buy: flat, threshold=1000, price=999 strobe → bytes 42 3A 30 30 39 39 39 0A, `position`=1, `order_count`=1, first `tx_start` at t+18 with a TX model busy for 10 cycles.
- Sell: long, `HYSTERESIS`=0, threshold=1000, price=1000 → no output. Then price=1001 → `S:01001\n`, `position`=0. Repeat with `HYSTERESIS`=5: 1005 produces no trade, 1006 sells.
- Equality while flat: price=threshold=500 → no `tx_start`, `busy` returns low at t+2.
- Burst: three strobes (prices 10, 20, 30; threshold 100; flat, `COOLDOWN_CYCLES`=4) while the first order is transmitting → first order `B:00010\n`, then `dropped_count`=1 and price 30 is evaluated after cooldown (long, so no trade).
- Full scale: long, threshold=0, price=65535 → `S:65535\n`. A TX model with `tx_busy` stuck high for 200 cycles stalls SEND with no duplicate `tx_start`.
